seq_game_engine: RTL
====================

# seq_game_engine

Parametrised round engine for the memory game. It stores the growing symbol sequence in an indexed array and appends one random symbol per round. It plays the sequence on one-hot LEDs with programmable on/off times, then checks player entries one at a time in forward or reverse order. It sits between the LFSR/mode-select logic and the LED/button I/O, and replaces the per-mode FSM, shift-register, counter and comparator chain.

## Interface
- SYM_W, 3, symbol width; LED count is 2**SYM_W
- MAX_LEN, 25, maximum sequence length (rounds to win)
- ON_CYC, 8, cycles each symbol is lit during playback (≥1)
- OFF_CYC, 4, dark cycles after each symbol (≥1)
- TIMEOUT_CYC, 64, idle cycles allowed per entry (used only with SEQ_TIMEOUT_EN)
- LEN_W = $clog2(MAX_LEN+1), derived, not overridable

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; begins a new game from IDLE, FAIL or WIN
- reverse  in  1  order select, sampled only when start is accepted: 0 forward, 1 reverse
- rand_sym  in  SYM_W  random symbol, sampled in APPEND
- in_valid  in  1  player entry strobe
- in_sym  in  SYM_W  player symbol, qualified by in_valid
- in_ready  out  1  high only in COLLECT
- led  out  2**SYM_W  one-hot during SHOW_ON, otherwise 0
- score  out  LEN_W  length of the last fully matched sequence
- round_pass  out  1  one-cycle pulse on a completed correct round
- fail  out  1  level, high in FAIL
- win  out  1  level, high in WIN
- timeout  out  1  level, high in FAIL when the failure was caused by timeout

## Operation
- States: IDLE, APPEND, SHOW_ON, SHOW_OFF, COLLECT, FAIL, WIN.
- IDLE: start → latch reverse, len←0, score←0, go to APPEND.
- APPEND (1 cycle): mem[len]←rand_sym, len←len+1, idx←0, go to SHOW_ON.
- SHOW_ON: led = onehot(mem[idx]) for ON_CYC cycles, then go to SHOW_OFF.
- SHOW_OFF: led=0 for OFF_CYC cycles. Then, if idx==len-1, go to COLLECT with pos←0. Otherwise idx←idx+1 and return to SHOW_ON.
- COLLECT: expected symbol = reverse ? mem[len-1-pos] : mem[pos].
  - in_valid with mismatch → FAIL.
  - Match with pos<len-1 → pos←pos+1.
  - Match with pos==len-1 → score←len and round_pass pulse. Then go to WIN if len==MAX_LEN, else to APPEND.
- FAIL/WIN: hold state and score. start → same action as in IDLE.
- in_valid outside COLLECT is ignored.
- start in APPEND/SHOW_*/COLLECT is ignored.
- Arithmetic: len, idx and pos are LEN_W-bit values. len never exceeds MAX_LEN. The playback and phase counters never wrap.

## Timing
- Reset values: state IDLE, led 0, in_ready 0, score 0, round_pass 0, fail 0, win 0, timeout 0. mem contents are don't-care.
- rst_n asserted mid-operation (any state) → all outputs return to reset values immediately. After release, the block waits for start.
- start accepted at edge k → APPEND during cycle k+1 → led first lit in cycle k+2.
- Playback of length L lasts exactly L·(ON_CYC+OFF_CYC) cycles. in_ready rises the cycle after the last dark cycle.
- Each in_valid is evaluated in the cycle it is presented. The state change takes effect at the next edge.
- round_pass is high for exactly one cycle. That is the cycle after the final matching entry, and score is updated in the same cycle.
- in_valid in the cycle before in_ready rises is not accepted.
- All outputs are registered or decoded from registered state only. There is no combinational path from an input to any output.

## Configuration
- SEQ_TIMEOUT_EN defined:
  - A counter clears on entry to COLLECT and on each accepted symbol.
  - Reaching TIMEOUT_CYC idle cycles in COLLECT → FAIL with timeout=1.
  - A start that leaves FAIL clears timeout.
- SEQ_TIMEOUT_EN undefined:
  - No counter is built and the timeout output is tied to 0.
  - COLLECT waits indefinitely.

## Test plan
- Reset: hold rst_n low, toggle all inputs → every output stays 0. Release and idle 20 cycles → outputs still 0.
- Forward round: start with rand_sym=5 → led=8'b0010_0000 in cycles k+2..k+9, 0 for 4 cycles, then in_ready=1. Enter in_sym=5 → round_pass pulse, score=1, round 2 plays two symbols over 24 cycles.
- Reverse order: reverse=1, pattern 2,6.
  - Entries 6,2 → pass, score=2.
  - On restart with pattern 2,6, entries 2 → fail=1 on the first entry, score frozen at its prior value.
- Win boundary: MAX_LEN=3, three correct rounds → win=1, score=3, led=0, later in_valid ignored. start → score=0, new game.
- Timeout (TIMEOUT_CYC=64): with SEQ_TIMEOUT_EN, no entry for 64 cycles in COLLECT → fail=1, timeout=1. Without the macro, still in COLLECT after 1000 cycles with timeout=0.
- Mid-operation events:
  - in_valid during SHOW_ON → ignored, playback unchanged.
  - start during COLLECT → ignored.
  - rst_n pulse during SHOW_ON → led=0 at once, IDLE after release.

Source files
------------

// File: rtl/seq_game_engine.sv
// Round engine for the memory game: grows a random symbol sequence, plays it on one-hot LEDs
// and checks player entries in forward or reverse order. Define SEQ_TIMEOUT_EN to enable the entry timeout.
module seq_game_engine #(
    parameter int SYM_W       = 3,
    parameter int MAX_LEN     = 25,
    parameter int ON_CYC      = 8,
    parameter int OFF_CYC     = 4,
    parameter int TIMEOUT_CYC = 64,
    localparam int LEN_W      = $clog2(MAX_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  reverse,
    input  logic [SYM_W-1:0]      rand_sym,
    input  logic                  in_valid,
    input  logic [SYM_W-1:0]      in_sym,
    output logic                  in_ready,
    output logic [2**SYM_W-1:0]   led,
    output logic [LEN_W-1:0]      score,
    output logic                  round_pass,
    output logic                  fail,
    output logic                  win,
    output logic                  timeout
);

    localparam int IDX_W  = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  ON_LAST  = PH_W'(ON_CYC - 1);
    localparam logic [PH_W-1:0]  OFF_LAST = PH_W'(OFF_CYC - 1);

    if (MAX_LEN < 1 || ON_CYC < 1 || OFF_CYC < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("seq_game_engine: MAX_LEN, ON_CYC, OFF_CYC and TIMEOUT_CYC must all be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPEND,
        S_SHOW_ON,
        S_SHOW_OFF,
        S_COLLECT,
        S_FAIL,
        S_WIN
    } state_t;

    state_t           state;
    logic [SYM_W-1:0] mem [0:MAX_LEN-1];
    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] idx;
    logic [LEN_W-1:0] pos;
    logic [PH_W-1:0]  ph_cnt;
    logic             rev_q;

    logic [LEN_W-1:0] last_idx;
    logic [LEN_W-1:0] exp_addr;
    logic [SYM_W-1:0] show_sym;
    logic [SYM_W-1:0] exp_sym;
    logic             entry_match;

`ifdef SEQ_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0] to_cnt;
    logic            timeout_q;

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    // Reverse order walks the stored sequence from its newest entry back to the first.
    always_comb begin
        last_idx    = len - LEN_ONE;
        exp_addr    = rev_q ? (last_idx - pos) : pos;
        show_sym    = mem[idx[IDX_W-1:0]];
        exp_sym     = mem[exp_addr[IDX_W-1:0]];
        entry_match = (in_sym == exp_sym);
    end

    always_comb begin
        led = '0;
        if (state == S_SHOW_ON) begin
            led[show_sym] = 1'b1;
        end
    end

    assign in_ready = (state == S_COLLECT);
    assign fail     = (state == S_FAIL);
    assign win      = (state == S_WIN);

    // The sequence store needs no reset: entries are always written before they are read.
    always_ff @(posedge clk) begin
        if (state == S_APPEND) begin
            mem[len[IDX_W-1:0]] <= rand_sym;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            len        <= '0;
            idx        <= '0;
            pos        <= '0;
            ph_cnt     <= '0;
            rev_q      <= 1'b0;
            score      <= '0;
            round_pass <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
            to_cnt     <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            round_pass <= 1'b0;
            case (state)
                S_IDLE, S_FAIL, S_WIN: begin
                    if (start) begin
                        rev_q <= reverse;
                        len   <= '0;
                        score <= '0;
`ifdef SEQ_TIMEOUT_EN
                        timeout_q <= 1'b0;
`endif
                        state <= S_APPEND;
                    end
                end

                S_APPEND: begin
                    len    <= len + LEN_ONE;
                    idx    <= '0;
                    ph_cnt <= '0;
                    state  <= S_SHOW_ON;
                end

                S_SHOW_ON: begin
                    if (ph_cnt == ON_LAST) begin
                        ph_cnt <= '0;
                        state  <= S_SHOW_OFF;
                    end else begin
                        ph_cnt <= ph_cnt + PH_ONE;
                    end
                end

                S_SHOW_OFF: begin
                    if (ph_cnt == OFF_LAST) begin
                        ph_cnt <= '0;
                        if (idx == last_idx) begin
                            pos   <= '0;
`ifdef SEQ_TIMEOUT_EN
                            to_cnt <= '0;
`endif
                            state <= S_COLLECT;
                        end else begin
                            idx   <= idx + LEN_ONE;
                            state <= S_SHOW_ON;
                        end
                    end else begin
                        ph_cnt <= ph_cnt + PH_ONE;
                    end
                end

                S_COLLECT: begin
                    if (in_valid) begin
`ifdef SEQ_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                        if (!entry_match) begin
                            state <= S_FAIL;
                        end else if (pos == last_idx) begin
                            score      <= len;
                            round_pass <= 1'b1;
                            state      <= (len == LEN_MAX) ? S_WIN : S_APPEND;
                        end else begin
                            pos <= pos + LEN_ONE;
                        end
                    end
`ifdef SEQ_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        timeout_q <= 1'b1;
                        state     <= S_FAIL;
                    end else begin
                        to_cnt <= to_cnt + TO_ONE;
                    end
`endif
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
